seg7_scan_ctrl: RTL and testbench

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

---
 rtl/seg7_scan_ctrl.sv | 125 ++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed 7-segment driver with per-frame input snapshot and PWM brightness.
// Leading-zero blanking is enabled by defining SEG7_BLANK_LZ_EN.
module seg7_scan_ctrl #(
   parameter int unsigned N_DIGITS     = 8,
   parameter int unsigned SLICE_CYCLES = 6250
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*N_DIGITS-1:0]   in_num,
   input  logic [N_DIGITS-1:0]     dp_in,
   input  logic [N_DIGITS-1:0]     digit_en,
   input  logic                    turn_on,
   input  logic [3:0]              brightness,
   output logic [7:0]              D7S,
   output logic [N_DIGITS-1:0]     AN,
   output logic                    frame_start
);

   localparam int unsigned SW = (SLICE_CYCLES > 1) ? $clog2(SLICE_CYCLES) : 1;
   localparam int unsigned IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

   logic [SW-1:0]           slice_q, slice_d;
   logic [3:0]              phase_q, phase_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [4*N_DIGITS-1:0]   num_q, num_d;
   logic [N_DIGITS-1:0]     dp_q, dp_d;
   logic [N_DIGITS-1:0]     en_q, en_d;
   logic [7:0]              d7s_q, d7s_d;
   logic [N_DIGITS-1:0]     an_q, an_d;
   logic                    fs_q, fs_d;

   logic                    load, slice_wrap, phase_wrap;
   logic                    lit, blank, dp_sel, en_sel;
   logic [3:0]              nib;
   logic [N_DIGITS-1:0]     sel;

   function automatic logic [6:0] glyph(input logic [3:0] v);
      logic [6:0] g;
      case (v)
         4'h0: g = 7'h40;  4'h1: g = 7'h79;  4'h2: g = 7'h24;  4'h3: g = 7'h30;
         4'h4: g = 7'h19;  4'h5: g = 7'h12;  4'h6: g = 7'h02;  4'h7: g = 7'h78;
         4'h8: g = 7'h00;  4'h9: g = 7'h10;  4'hA: g = 7'h08;  4'hB: g = 7'h03;
         4'hC: g = 7'h46;  4'hD: g = 7'h21;  4'hE: g = 7'h06;  default: g = 7'h0E;
      endcase
      return g;
   endfunction

   always_comb begin
      slice_wrap = (slice_q == SW'(SLICE_CYCLES - 1));
      phase_wrap = (phase_q == 4'hF);
      load       = (slice_q == '0) && (phase_q == '0) && (idx_q == '0);
      slice_d    = slice_wrap ? '0 : slice_q + 1'b1;
      phase_d    = phase_q;
      idx_d      = idx_q;
      if (slice_wrap) begin
         phase_d = phase_q + 4'd1;
         if (phase_wrap)
            idx_d = (idx_q == IW'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end
   end

   // Output stage reads the post-load snapshot so a load cycle never shows the old glyph.
   always_comb begin
      num_d = load ? in_num   : num_q;
      dp_d  = load ? dp_in    : dp_q;
      en_d  = load ? digit_en : en_q;
   end

   always_comb begin
      nib    = '0;
      dp_sel = 1'b0;
      en_sel = 1'b0;
      sel    = '0;
      for (int unsigned i = 0; i < N_DIGITS; i++) begin
         if (idx_q == IW'(i)) begin
            sel[i] = 1'b1;
            nib    = num_d[4*i +: 4];
            dp_sel = dp_d[i];
            en_sel = en_d[i];
         end
      end
`ifdef SEG7_BLANK_LZ_EN
      blank = (idx_q != '0);
      for (int unsigned i = 0; i < N_DIGITS; i++) begin
         if ((IW'(i) >= idx_q) && (num_d[4*i +: 4] != 4'h0))
            blank = 1'b0;
      end
`else
      blank = 1'b0;
`endif
      lit   = turn_on && en_sel && (phase_q <= brightness) && !blank;
      an_d  = lit ? ~sel : '1;
      d7s_d = lit ? {~dp_sel, glyph(nib)} : 8'hFF;
      fs_d  = load;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         slice_q <= '0;
         phase_q <= '0;
         idx_q   <= '0;
         num_q   <= '0;
         dp_q    <= '0;
         en_q    <= '0;
         an_q    <= '1;
         d7s_q   <= 8'hFF;
         fs_q    <= 1'b0;
      end else begin
         slice_q <= slice_d;
         phase_q <= phase_d;
         idx_q   <= idx_d;
         num_q   <= num_d;
         dp_q    <= dp_d;
         en_q    <= en_d;
         an_q    <= an_d;
         d7s_q   <= d7s_d;
         fs_q    <= fs_d;
      end
   end

   assign D7S         = d7s_q;
   assign AN          = an_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomized bench for seg7_scan_ctrl (N_DIGITS=4, SLICE_CYCLES=2) against a frame-position model.
// Honours SEG7_BLANK_LZ_EN the same way as the design build.
module tb_seg7_scan_ctrl;

`ifdef SEG7_BLANK_LZ_EN
   localparam bit LZ = 1'b1;
`else
   localparam bit LZ = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] in_num;
   logic [3:0]  dp_in, digit_en, brightness;
   logic        turn_on;
   logic [7:0]  D7S;
   logic [3:0]  AN;
   logic        frame_start;

   int n_checks = 0;
   int n_errors = 0;

   seg7_scan_ctrl #(.N_DIGITS(4), .SLICE_CYCLES(2)) dut (
      .clk(clk), .reset(reset), .in_num(in_num), .dp_in(dp_in),
      .digit_en(digit_en), .turn_on(turn_on), .brightness(brightness),
      .D7S(D7S), .AN(AN), .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Active-high a..g shapes; the display wants them inverted.
   function automatic logic [6:0] shape(input logic [3:0] v);
      logic [6:0] s [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      return s[v];
   endfunction

   function automatic bit lz_blank(input logic [15:0] num, input int dig);
      return LZ && (dig > 0) && ((num >> (4 * dig)) == 16'h0);
   endfunction

   // Model: position within the 128-cycle frame; dwell 32 per digit, 2 cycles per phase.
   int          pos;
   logic [15:0] m_num;
   logic [3:0]  m_dp, m_en;
   logic [3:0]  exp_an;
   logic [7:0]  exp_d7s;
   logic        exp_fs;
   bit          mdl_valid = 1'b0;

   always @(posedge clk) begin : model
      int dig, ph;
      bit lit;
      mdl_valid = 1'b1;
      if (reset) begin
         pos = 0; m_num = '0; m_dp = '0; m_en = '0;
         exp_an = 4'hF; exp_d7s = 8'hFF; exp_fs = 1'b0;
      end else begin
         if (pos == 0) begin
            m_num = in_num; m_dp = dp_in; m_en = digit_en;
         end
         exp_fs  = (pos == 0);
         dig     = pos / 32;
         ph      = (pos % 32) / 2;
         lit     = turn_on && m_en[dig] && (ph <= int'(brightness)) && !lz_blank(m_num, dig);
         exp_an  = 4'hF;
         exp_d7s = 8'hFF;
         if (lit) begin
            exp_an[dig] = 1'b0;
            exp_d7s     = {~m_dp[dig], ~shape(m_num[dig*4 +: 4])};
         end
         pos = (pos + 1) % 128;
      end
   end

   always @(negedge clk) begin
      if (mdl_valid) begin
         chk("an", {28'h0, AN}, {28'h0, exp_an});
         chk("d7s", {24'h0, D7S}, {24'h0, exp_d7s});
         chk("frame_start", {31'h0, frame_start}, {31'h0, exp_fs});
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; in_num = '0; dp_in = '0; digit_en = '0; turn_on = 1'b0; brightness = '0;
      cycles(3);
      chk("reset_an", {28'h0, AN}, 32'hF);
      chk("reset_d7s", {24'h0, D7S}, 32'hFF);
      chk("reset_fs", {31'h0, frame_start}, 32'h0);

      in_num = 16'h1234; digit_en = 4'hF; brightness = 4'd15; turn_on = 1'b1; dp_in = 4'h0;
      reset = 1'b0;
      cycles(1);
      chk("first_fs", {31'h0, frame_start}, 32'h1);
      chk("first_an", {28'h0, AN}, 32'hE);
      chk("first_d7s", {24'h0, D7S}, 32'h99);
      cycles(32);
      chk("dig1_an", {28'h0, AN}, 32'hD);
      chk("dig1_d7s", {24'h0, D7S}, 32'hB0);
      cycles(96);

      brightness = 4'd3;
      cycles(128 + 72);
      in_num = 16'hABCD;
      cycles(200);
      in_num = 16'h0050;
      cycles(256);
      dp_in = 4'b0010;
      cycles(128);
      turn_on = 1'b0;
      cycles(70);
      turn_on = 1'b1;

      while (pos != 70) cycles(1);
      reset = 1'b1;
      cycles(1);
      chk("midreset_an", {28'h0, AN}, 32'hF);
      chk("midreset_d7s", {24'h0, D7S}, 32'hFF);
      reset = 1'b0;
      cycles(1);
      chk("post_reset_fs", {31'h0, frame_start}, 32'h1);
      chk("post_reset_an", {28'h0, AN}, 32'hE);
      chk("post_reset_d7s", {24'h0, D7S}, 32'hC0);
      cycles(1);
      chk("post_reset_fs_once", {31'h0, frame_start}, 32'h0);

      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 19) == 0) begin
            case ($urandom_range(0, 5))
               0: in_num     = 16'($urandom);
               1: in_num     = 16'($urandom_range(0, 255));
               2: dp_in      = 4'($urandom);
               3: digit_en   = 4'($urandom);
               4: brightness = 4'($urandom);
               default: turn_on = ($urandom_range(0, 3) != 0);
            endcase
         end
         reset = ($urandom_range(0, 499) == 0);
         cycles(1);
      end
      reset = 1'b0;
      cycles(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
